// File: rtl/axi_pkg.sv
// AXI protocol encodings and responder FSM state types, shared with the core's initiator.
// Latency: none, constants and types only.
// Backpressure: not applicable; handshaking lives in the modules that import this package.
package axi_pkg;

  // Burst encodings; 2'b11 is reserved and not named here.
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  // Response encodings carried on B and R.
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // Write channel: address accepted -> data beats -> response.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // Read channel: address accepted -> data beats.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Only FIXED holds the address; WRAP and reserved step like INCR.
  function automatic logic is_fixed(input logic [1:0] burst);
    return burst == BURST_FIXED;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed storage with one byte-strobed write port and one asynchronous read port.
// Latency: write lands at the clock edge; read is combinational, so a same-cycle read sees old data.
// Backpressure: none, always ready; contents are never reset.
module axi_mem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-granular write: only strobed lanes change.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: FIXED/INCR bursts on independent read and write channels.
// Latency: R beat 0 one cycle after AR handshake, then 1 beat/cycle; B one cycle after last W.
// Backpressure: R and B held stable until ready; one outstanding burst per channel.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        axi_aw_valid_i,
  output logic                        axi_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [7:0]                  axi_aw_len_i,
  input  logic [1:0]                  axi_aw_burst_i,
  input  logic                        axi_w_valid_i,
  output logic                        axi_w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                        axi_w_last_i,
  output logic                        axi_b_valid_o,
  input  logic                        axi_b_ready_i,
  output logic [1:0]                  axi_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
  input  logic                        axi_ar_valid_i,
  output logic                        axi_ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
  input  logic [7:0]                  axi_ar_len_i,
  input  logic [1:0]                  axi_ar_burst_i,
  output logic                        axi_r_valid_o,
  input  logic                        axi_r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
  output logic [1:0]                  axi_r_resp_o,
  output logic                        axi_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o
);

  localparam int BEAT  = AXI_DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BEAT);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Anything at or above MEM_DEPTH*BEAT bytes decodes to nothing.
  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + OFF_W)) == '0;
  endfunction

  function automatic logic [AXI_ADDR_WIDTH-1:0] step_addr(input logic [AXI_ADDR_WIDTH-1:0] a,
                                                          input logic [1:0] burst);
    return is_fixed(burst) ? a : a + AXI_ADDR_WIDTH'(BEAT);
  endfunction

  // ---------------- write channel ----------------
  w_state_t                  w_state, w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [AXI_ID_WIDTH-1:0]   w_id;
  logic [7:0]                w_len;
  logic [7:0]                w_cnt;
  logic [1:0]                w_burst;
  logic                      w_err;
  logic                      aw_hs, w_hs, w_final, w_beat_err, mem_we;

  assign aw_hs      = axi_aw_valid_i && axi_aw_ready_o;
  assign w_hs       = axi_w_valid_i && axi_w_ready_o;
  // Burst length comes from the counter; w_last is only checked, never trusted.
  assign w_final    = (w_cnt == w_len);
  assign w_beat_err = !in_range(w_addr) || (axi_w_last_i != w_final);
  assign mem_we     = w_hs && in_range(w_addr);

  // Write FSM state register.
  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  // Write FSM next state and channel readies; readies are held low through reset.
  always_comb begin
    w_state_nxt    = w_state;
    axi_aw_ready_o = 1'b0;
    axi_w_ready_o  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        axi_aw_ready_o = !reset;
        if (axi_aw_valid_i && !reset) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi_w_ready_o = !reset;
        if (axi_w_valid_i && !reset && w_final) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (axi_b_ready_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst bookkeeping and B response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_addr        <= '0;
      w_id          <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
      axi_b_valid_o <= 1'b0;
      axi_b_resp_o  <= RESP_OKAY;
      axi_b_id_o    <= '0;
    end else begin
      if (aw_hs) begin
        w_addr  <= axi_aw_addr_i;
        w_id    <= axi_aw_id_i;
        w_len   <= axi_aw_len_i;
        w_burst <= axi_aw_burst_i;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= step_addr(w_addr, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err | w_beat_err;
        if (w_final) begin
          axi_b_valid_o <= 1'b1;
          axi_b_resp_o  <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
          axi_b_id_o    <= w_id;
        end
      end
      if (axi_b_valid_o && axi_b_ready_i) axi_b_valid_o <= 1'b0;
    end
  end

  // ---------------- read channel ----------------
  r_state_t                  r_state, r_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_ADDR_WIDTH-1:0] fetch_addr;
  logic [7:0]                r_len;
  logic [7:0]                r_cnt;
  logic [1:0]                r_burst;
  logic                      ar_hs, r_hs, r_final, r_load;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;

  assign ar_hs   = axi_ar_valid_i && axi_ar_ready_o;
  assign r_hs    = axi_r_valid_o && axi_r_ready_i;
  assign r_final = (r_cnt == r_len);

  // Read FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  // Read FSM: choose the fetch address and when to register the next beat.
  always_comb begin
    r_state_nxt    = r_state;
    axi_ar_ready_o = 1'b0;
    r_load         = 1'b0;
    fetch_addr     = axi_ar_addr_i;
    unique case (r_state)
      R_IDLE: begin
        axi_ar_ready_o = !reset;
        if (axi_ar_valid_i && !reset) begin
          r_state_nxt = R_DATA;
          r_load      = 1'b1;
        end
      end
      R_DATA: begin
        fetch_addr = step_addr(r_addr, r_burst);
        if (r_hs) begin
          if (r_final) r_state_nxt = R_IDLE;
          else         r_load      = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // R output registers: load a fresh beat or retire the burst, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_burst       <= '0;
      axi_r_valid_o <= 1'b0;
      axi_r_data_o  <= '0;
      axi_r_resp_o  <= RESP_OKAY;
      axi_r_last_o  <= 1'b0;
      axi_r_id_o    <= '0;
    end else begin
      if (ar_hs) begin
        axi_r_id_o <= axi_ar_id_i;
        r_len      <= axi_ar_len_i;
        r_burst    <= axi_ar_burst_i;
        r_cnt      <= '0;
      end
      if (r_load) begin
        r_addr        <= fetch_addr;
        axi_r_valid_o <= 1'b1;
        axi_r_data_o  <= in_range(fetch_addr) ? mem_rdata : '0;
        axi_r_resp_o  <= in_range(fetch_addr) ? RESP_OKAY : RESP_SLVERR;
        if (ar_hs) begin
          axi_r_last_o <= (axi_ar_len_i == 8'd0);
        end else begin
          axi_r_last_o <= (r_cnt + 8'd1 == r_len);
          r_cnt        <= r_cnt + 8'd1;
        end
      end else if (r_hs) begin
        axi_r_valid_o <= 1'b0;
        axi_r_last_o  <= 1'b0;
      end
    end
  end

  axi_mem_array #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (AXI_DATA_WIDTH)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (w_addr[IDX_W+OFF_W-1:OFF_W]),
    .wdata (axi_w_data_i),
    .wstrb (axi_w_strb_i),
    .raddr (fetch_addr[IDX_W+OFF_W-1:OFF_W]),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 responder (slave) backed by an on-chip word-addressed memory.
- It is the far end of the core's AXI initiator. It accepts FIXED/INCR bursts on independent read and write channels and returns R data and B responses.
- It serves as the simulation/FPGA main-memory model behind the core's bus and as a scratchpad slave.
- Sideband signals (prot/cache/qos/region/lock/user/size) are not ported. The top level leaves the initiator's outputs unconnected. All transfers are full data width.

Parameters:
- AXI_DATA_WIDTH, 64, data bus width; beat = AXI_DATA_WIDTH/8 bytes.
- AXI_ADDR_WIDTH, 64, address width.
- AXI_ID_WIDTH, 4, transaction ID width.
- MEM_DEPTH, 1024, number of data-width words in the array (power of 2).

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- axi_aw_valid_i  in  1  write address valid.
- axi_aw_ready_o  out  1  write address accepted.
- axi_aw_addr_i  in  AXI_ADDR_WIDTH  burst start byte address.
- axi_aw_id_i  in  AXI_ID_WIDTH  write ID, echoed on B.
- axi_aw_len_i  in  8  beats minus 1.
- axi_aw_burst_i  in  2  burst type.
- axi_w_valid_i  in  1  write data valid.
- axi_w_ready_o  out  1  write data accepted.
- axi_w_data_i  in  AXI_DATA_WIDTH  write data.
- axi_w_strb_i  in  AXI_DATA_WIDTH/8  byte enables.
- axi_w_last_i  in  1  final write beat.
- axi_b_valid_o  out  1  write response valid.
- axi_b_ready_i  in  1  write response accepted.
- axi_b_resp_o  out  2  OKAY=00, SLVERR=10.
- axi_b_id_o  out  AXI_ID_WIDTH  latched AW ID.
- axi_ar_valid_i  in  1  read address valid.
- axi_ar_ready_o  out  1  read address accepted.
- axi_ar_addr_i  in  AXI_ADDR_WIDTH  burst start byte address.
- axi_ar_id_i  in  AXI_ID_WIDTH  read ID.
- axi_ar_len_i  in  8  beats minus 1.
- axi_ar_burst_i  in  2  burst type.
- axi_r_valid_o  out  1  read data valid.
- axi_r_ready_i  in  1  read data accepted.
- axi_r_data_o  out  AXI_DATA_WIDTH  read data.
- axi_r_resp_o  out  2  OKAY/SLVERR per beat.
- axi_r_last_o  out  1  final read beat.
- axi_r_id_o  out  AXI_ID_WIDTH  latched AR ID.

Behaviour:
- Reset: both FSMs go to IDLE. b_valid, r_valid, r_last = 0; resp = 00; ids/r_data = 0. Readies are forced 0 while reset=1.
- Memory contents are not reset.
- Word index = addr[log2(MEM_DEPTH)+log2(beat)-1 : log2(beat)]. Low offset bits are ignored.
- A beat whose address ≥ MEM_DEPTH*beat is out of range.
- Burst stepping:
  - INCR: address += beat bytes per beat.
  - FIXED: address constant.
  - WRAP (10) and reserved (11) are treated as INCR.
  - No 4KB boundary check.
- Write FSM: W_IDLE → W_DATA → W_RESP.
  - W_IDLE: aw_ready=1. On AW handshake, latch addr/id/len/burst, clear beat counter and error flag, go to W_DATA. The next AW is not accepted until W_RESP completes.
  - W_DATA: w_ready=1. Each W handshake writes enabled bytes to the array in that cycle, then advances address and counter.
  - Out-of-range beat: write dropped, error flag set.
  - Last-flag mismatch sets the error flag: w_last=1 on a non-final beat, or w_last=0 on the final beat. Termination is by counter == len, never by w_last.
  - After the final beat: go to W_RESP with b_valid=1, b_resp = error ? 10 : 00, b_id = latched id.
  - W_RESP: hold b_valid and all B fields until b_ready. Return to W_IDLE the cycle after the handshake; aw_ready=1 in that cycle.
- Read FSM: R_IDLE → R_DATA.
  - R_IDLE: ar_ready=1. An AR handshake in cycle T latches id/len/burst. It drives r_valid=1, beat 0 data, and r_last=(len==0) registered at T+1.
  - R_DATA: outputs are stable while r_valid && !r_ready. On an R handshake with a non-final beat, the next beat is registered for the following cycle (1 beat/cycle at r_ready=1).
  - Out-of-range beat: r_data=0, r_resp=10. Otherwise r_resp=00.
  - On the final-beat handshake: r_valid=0 and r_last=0 next cycle, return to R_IDLE.
- Channel independence: read and write FSMs run concurrently.
  - Same-cycle write and read-fetch to one word: the read returns old data.
  - A word written at cycle T is visible to fetches at T+1 and later.
- len=255 gives 256 beats; the 8-bit counter must not wrap early.
- Reset mid-burst aborts both channels immediately. No B/R is issued for the aborted transaction. Partially written words stay written.

Decomposition:
- axi_pkg holds the shared constants: burst types (FIXED/INCR/WRAP), resp codes (OKAY/EXOKAY/SLVERR/DECERR), and the write/read FSM state enums. The core's initiator shares the burst codes.
- One sub-module, axi_mem_array: MEM_DEPTH×AXI_DATA_WIDTH array with 1 write port (per-byte strobe) and 1 asynchronous read port. No reset.

Test Plan:
- Single write, then read. AW addr=0x40 len=0 INCR, W data=0x1122334455667788 strb=0xFF last=1 → b_resp=00, b_id=AW id. AR addr=0x40 len=0 → r_data=0x1122334455667788, r_last=1, r_valid exactly 1 cycle after the AR handshake.
- INCR burst with backpressure. Write 8 beats 0..7 at 0x100. Read len=7 with r_ready toggling 1,0,1,0 → data 0..7 in order, held stable while stalled, r_last only on beat 7.
- Partial strobe. Pre-write 0xFFFFFFFFFFFFFFFF at 0x8, then write 0 with strb=0x0F → read returns 0xFFFFFFFF00000000.
- FIXED burst. Write len=3 at 0x20 with data A,B,C,D → read 0x20 returns D; 0x28 is unchanged.
- Errors:
  - Write at MEM_DEPTH*8 → b_resp=10, array unchanged.
  - Write len=1 with w_last=1 on beat 0 → b_resp=10.
  - Read at out-of-range address → r_data=0, r_resp=10.
- Concurrency and reset. Overlapping read and write bursts on separate IDs complete with correct IDs. Reset asserted mid read burst → r_valid=0 the next cycle; ar_ready=1 the cycle after reset deasserts.
